display_scan_driver: RTL and testbench
======================================

Name: display_scan_driver

Overview:
Drives a two-digit, common-anode 7-segment display from a 4-bit binary value in the range 0..15. It splits the value into tens and units digits and time-multiplexes the two anodes from its own prescaler. It inserts a blanking guard at every digit switch to prevent ghosting. It is the display-side consumer of the tens/units decision: it takes a loaded value and turns it into anode and segment signals for the board pins.

Parameters:
TICK_DIV, 100000, clk cycles per digit slot; must be >= GUARD+2.
GUARD, 4, cycles at the start of each slot during which both anodes are off; must be >= 0.
BLANK_LZ, 1, 1 = suppress the tens digit when it is 0.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
value  in  4  binary value to display
load  in  1  1-cycle strobe; captures value into the pending register
an  out  2  anodes, active-low; an[0] = units, an[1] = tens
seg  out  7  segments, active-low, order {g,f,e,d,c,b,a}
frame_start  out  1  1-cycle pulse when the units slot begins
pending  out  1  1 while a loaded value is waiting to be applied

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values, applied immediately on rst_n low:
  - an=2'b11, seg=7'h7F, frame_start=0, pending=0.
  - Internal state: slot counter cnt=0, state=DIG_U, active=0, pend_val=0.
- Slot counter:
  - cnt runs 0..TICK_DIV-1 and wraps to 0.
  - A slot ends in the cycle where cnt==TICK_DIV-1.
- FSM, two states: DIG_U (units) and DIG_T (tens).
  - At slot end, DIG_U -> DIG_T and DIG_T -> DIG_U.
  - A frame is DIG_U then DIG_T, i.e. 2*TICK_DIV cycles.
  - The first slot after reset is DIG_U with cnt=0.
- frame_start: asserted for 1 cycle in the first cycle of each DIG_U slot, including the first cycle after reset release.
- Load handshake:
  - load=1 sets pend_val<=value and pending<=1.
  - Repeated loads before a frame boundary overwrite pend_val; the last one wins.
- Apply point:
  - On the DIG_T->DIG_U transition, if pending=1: active<=pend_val and pending<=0.
  - If load coincides with that transition, the new value bypasses pend_val: active<=value and pending stays 0.
  - active never changes mid-frame, so there is no tearing between digits.
- Digit split:
  - tens = (active>=10) ? 1 : 0.
  - units = (active>=10) ? active-10 : active.
  - Results are 4-bit, range 0..9 only.
- Segment encoding, active-low hex: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Anode rule:
  - Digit anode is low only when cnt>=GUARD in its own slot.
  - With BLANK_LZ=1 and tens==0, an[1] stays 1 for the whole DIG_T slot.
  - an is never 2'b00.
  - seg shows the current slot's digit code for the whole slot. It is 7'h7F while the tens digit is blanked.
- Output timing:
  - an, seg and frame_start are registered.
  - The value in cycle t is decoded from (state, cnt, active) of cycle t-1, giving 1-cycle latency.
  - Because of this latency, the anode goes low GUARD+1 cycles after slot start.
- Reset mid-operation: any state, including the guard window or a pending load, goes straight to reset values. A pending load is discarded.
- value is only sampled on load; it is ignored at all other times.

Test Plan:
(All scenarios use TICK_DIV=8, GUARD=2, BLANK_LZ=1.)
1. Reset: pull rst_n low mid-slot -> an=11 and seg=7F in the same cycle. After release: frame_start pulses, units slot shows seg=40, an[0]=0 from cycle 3 to cycle 8, an[1]=1 through the whole tens slot.
2. load with value=13 at cycle 5 of a units slot -> pending=1. Display is unchanged until the next frame_start, then pending=0. Units slot: seg=30, an=10. Tens slot: seg=79, an=01. Anodes are 11 for the first 3 cycles of each slot.
3. load value=9 -> units seg=10. Tens slot has an=11 and seg=7F for all 8 cycles.
4. load value=15 exactly in the last cycle of a tens slot -> the next frame shows units seg=12 and tens seg=79, with pending never asserted. Two loads in one frame, 4 then 7 -> next frame shows 7 (seg=78).
5. rst_n low during a tens slot with pending=1 -> immediate blank. The restart shows 00 (units 40, tens blanked) and the pending value is lost.
6. Free run for 64 cycles -> frame_start has period 16. an never equals 00. Exactly 2*(8-2)=12 anode-active cycles per frame when tens≠0.

Source files
------------

// File: rtl/display_scan_driver.sv
//------------------------------------------------------------------------------
// display_scan_driver
//
// Drives a two-digit, common-anode 7-segment display from a 4-bit binary value
// (0..15). The value is split into a tens digit (0 or 1) and a units digit
// (0..9). The two anodes are time-multiplexed from an internal slot counter,
// and both anodes stay off for the first GUARD cycles of every slot so that
// the segment lines settle before a digit lights up (no ghosting).
//
// A value enters through the load strobe into a pending register. It becomes
// the displayed value only at the tens->units boundary, so both digits of one
// frame always come from the same value.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous reset, active-low
//   value[3:0]   in   binary value to display, sampled only when load=1
//   load         in   1-cycle strobe, captures value into the pending register
//   an[1:0]      out  anodes, active-low; an[0] = units, an[1] = tens
//   seg[6:0]     out  segments, active-low, order {g,f,e,d,c,b,a}
//   frame_start  out  1-cycle pulse when the units slot begins
//   pending      out  1 while a loaded value waits to be applied
//
// Parameters
//   TICK_DIV  clk cycles per digit slot (>= GUARD+2)
//   GUARD     blanking cycles at the start of each slot (>= 0)
//   BLANK_LZ  1 = suppress the tens digit when it is 0
//
// Timing: an, seg and frame_start are registered. Their value in cycle t is
// decoded from (state, cnt, active) of cycle t-1, so an anode turns on GUARD+1
// cycles after its slot begins and frame_start is seen one cycle after the
// units slot begins.
//------------------------------------------------------------------------------
module display_scan_driver #(
    parameter int TICK_DIV = 100000,
    parameter int GUARD    = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] value,
    input  logic       load,
    output logic [1:0] an,
    output logic [6:0] seg,
    output logic       frame_start,
    output logic       pending
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);

    localparam logic [0:0] DIG_U = 1'b0;  // units slot
    localparam logic [0:0] DIG_T = 1'b1;  // tens slot

    logic [CW-1:0] cnt;
    logic [0:0]    state;
    logic [3:0]    active;
    logic [3:0]    pend_val;

    logic          slot_end;
    logic          apply;
    logic          tens_nz;
    logic [3:0]    units;
    logic          in_guard;
    logic          tens_blank;
    logic [1:0]    next_an;
    logic [6:0]    next_seg;
    logic          next_frame_start;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    assign slot_end = (cnt == CNT_LAST);
    // The frame boundary: last cycle of the tens slot.
    assign apply    = slot_end && (state == DIG_T);

    //--------------------------------------------------------------------------
    // Digit split and next-output decode
    //--------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        tens_nz          = (active >= 4'd10);
        units            = tens_nz ? (active - 4'd10) : active;
        in_guard         = (cnt < GUARD_CNT);
        tens_blank       = (BLANK_LZ != 0) && !tens_nz;
        next_an          = 2'b11;
        next_seg         = 7'h7F;
        next_frame_start = (state == DIG_U) && (cnt == '0);

        if (state == DIG_U) begin
            next_seg = seg_code(units);
            if (!in_guard) next_an = 2'b10;
        end else if (!tens_blank) begin
            next_seg = seg_code({3'b000, tens_nz});
            if (!in_guard) next_an = 2'b01;
        end
    end

    //--------------------------------------------------------------------------
    // Slot counter and digit FSM
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            state <= DIG_U;
        end else if (slot_end) begin
            cnt   <= '0;
            state <= (state == DIG_U) ? DIG_T : DIG_U;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Load handshake and frame-synchronous apply
    //--------------------------------------------------------------------------
    // A load that coincides with the frame boundary goes straight to active;
    // otherwise the pending value is applied, and loads elsewhere only update
    // the pending register (last one wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= '0;
            pend_val <= '0;
            pending  <= 1'b0;
        end else if (apply) begin
            if (load) begin
                active <= value;
            end else if (pending) begin
                active <= pend_val;
            end
            pending <= 1'b0;
        end else if (load) begin
            pend_val <= value;
            pending  <= 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Registered pin outputs
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= 2'b11;
            seg         <= 7'h7F;
            frame_start <= 1'b0;
        end else begin
            an          <= next_an;
            seg         <= next_seg;
            frame_start <= next_frame_start;
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
//------------------------------------------------------------------------------
// tb_display_scan_driver
//
// Directed bench for display_scan_driver with TICK_DIV=8, GUARD=2, BLANK_LZ=1.
// k counts rising edges since the last reset release; outputs are sampled 1
// time unit after each edge. After edge k the outputs reflect slot position
// (k-1) mod 16 (0..7 units slot, 8..15 tens slot), and a pending value is
// applied on edges where k is a multiple of 16.
//------------------------------------------------------------------------------
module tb_display_scan_driver;

    logic       clk;
    logic       rst_n;
    logic [3:0] value;
    logic       load;
    logic [1:0] an;
    logic [6:0] seg;
    logic       frame_start;
    logic       pending;

    int n_checks = 0;
    int n_errors = 0;
    int k        = 0;

    display_scan_driver #(
        .TICK_DIV (8),
        .GUARD    (2),
        .BLANK_LZ (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .load        (load),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] e_an,
                             input logic [6:0] e_seg, input logic e_fs);
        check($sformatf("%s.an(k=%0d)", tag, k), {30'd0, an}, {30'd0, e_an});
        check($sformatf("%s.seg(k=%0d)", tag, k), {25'd0, seg}, {25'd0, e_seg});
        check($sformatf("%s.frame_start(k=%0d)", tag, k), {31'd0, frame_start}, {31'd0, e_fs});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic goto(input int target);
        while (k < target) tick(1);
    endtask

    // Strobe load for one edge, then put an unrelated value on the bus to show
    // that value is ignored while load is low.
    task automatic do_load(input logic [3:0] v);
        load  = 1'b1;
        value = v;
        tick(1);
        load  = 1'b0;
        value = ~v;
    endtask

    int fs_count;
    int first_fs_k;
    int last_fs_k;
    int bad_gaps;
    int an_zero;
    int an_active;

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        value = 4'd0;

        // Held reset
        repeat (2) @(posedge clk);
        #1;
        check_out("rst_hold", 2'b11, 7'h7F, 1'b0);
        check("rst_hold.pending", {31'd0, pending}, 32'd0);
        #5 rst_n = 1'b1;
        k = 0;

        // Asynchronous reset in the middle of a lit units slot
        tick(3);
        check_out("pre_rst", 2'b10, 7'h40, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_out("async_rst", 2'b11, 7'h7F, 1'b0);
        #2 rst_n = 1'b1;
        k = 0;

        // 1. Restart shows 00: units 0 lit after the guard, tens blanked
        tick(1);
        check_out("t1_start", 2'b11, 7'h40, 1'b1);
        check("t1_start.pending", {31'd0, pending}, 32'd0);
        tick(1);
        check_out("t1_guard", 2'b11, 7'h40, 1'b0);
        for (int i = 3; i <= 8; i++) begin
            tick(1);
            check_out("t1_units_on", 2'b10, 7'h40, 1'b0);
        end
        for (int i = 9; i <= 16; i++) begin
            tick(1);
            check_out("t1_tens_blank", 2'b11, 7'h7F, 1'b0);
        end

        // 2. Load 13 mid units slot; applied at the next frame boundary
        goto(21);
        do_load(4'd13);
        check("t2_load.pending", {31'd0, pending}, 32'd1);
        check_out("t2_unchanged", 2'b10, 7'h40, 1'b0);
        goto(31);
        check("t2_wait.pending", {31'd0, pending}, 32'd1);
        check_out("t2_wait", 2'b11, 7'h7F, 1'b0);
        tick(1);
        check("t2_apply.pending", {31'd0, pending}, 32'd0);
        check_out("t2_old_frame_end", 2'b11, 7'h7F, 1'b0);
        tick(1);
        check_out("t2_frame", 2'b11, 7'h30, 1'b1);
        tick(1);
        check_out("t2_u_guard", 2'b11, 7'h30, 1'b0);
        tick(1);
        check_out("t2_u_on", 2'b10, 7'h30, 1'b0);
        goto(41);
        check_out("t2_t_guard0", 2'b11, 7'h79, 1'b0);
        tick(1);
        check_out("t2_t_guard1", 2'b11, 7'h79, 1'b0);
        tick(1);
        check_out("t2_t_on", 2'b01, 7'h79, 1'b0);
        goto(48);
        check_out("t2_t_last", 2'b01, 7'h79, 1'b0);
        tick(1);
        check_out("t2_next_frame", 2'b11, 7'h30, 1'b1);

        // 3. Load 9: units 9, tens slot fully blank
        goto(50);
        do_load(4'd9);
        check("t3_load.pending", {31'd0, pending}, 32'd1);
        goto(64);
        check("t3_apply.pending", {31'd0, pending}, 32'd0);
        tick(1);
        check_out("t3_frame", 2'b11, 7'h10, 1'b1);
        goto(67);
        check_out("t3_u_on", 2'b10, 7'h10, 1'b0);
        goto(72);
        check_out("t3_u_last", 2'b10, 7'h10, 1'b0);
        for (int i = 73; i <= 80; i++) begin
            tick(1);
            check_out("t3_tens_blank", 2'b11, 7'h7F, 1'b0);
        end

        // 4a. Load 15 in the last cycle of the tens slot: bypasses pending
        goto(95);
        check("t4_pre.pending", {31'd0, pending}, 32'd0);
        do_load(4'd15);
        check("t4_bypass.pending", {31'd0, pending}, 32'd0);
        tick(1);
        check_out("t4_frame", 2'b11, 7'h12, 1'b1);
        check("t4_frame.pending", {31'd0, pending}, 32'd0);
        goto(99);
        check_out("t4_u_on", 2'b10, 7'h12, 1'b0);

        // 4b. Two loads in one frame: the last one wins
        goto(100);
        do_load(4'd4);
        goto(104);
        do_load(4'd7);
        check("t4_two.pending", {31'd0, pending}, 32'd1);
        check_out("t4_t_guard", 2'b11, 7'h79, 1'b0);
        goto(107);
        check_out("t4_t_on", 2'b01, 7'h79, 1'b0);
        goto(112);
        check("t4_apply.pending", {31'd0, pending}, 32'd0);
        tick(1);
        check_out("t4_last_wins", 2'b11, 7'h78, 1'b1);
        goto(115);
        check_out("t4_last_wins_on", 2'b10, 7'h78, 1'b0);
        goto(121);
        check_out("t4_t_blank0", 2'b11, 7'h7F, 1'b0);
        goto(123);
        check_out("t4_t_blank2", 2'b11, 7'h7F, 1'b0);

        // 5. Reset during a tens slot with a load pending: value is lost
        goto(124);
        do_load(4'd12);
        check("t5_load.pending", {31'd0, pending}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_out("t5_rst", 2'b11, 7'h7F, 1'b0);
        check("t5_rst.pending", {31'd0, pending}, 32'd0);
        #2 rst_n = 1'b1;
        k = 0;
        tick(1);
        check_out("t5_restart", 2'b11, 7'h40, 1'b1);
        goto(3);
        check_out("t5_u_on", 2'b10, 7'h40, 1'b0);
        goto(11);
        check_out("t5_t_blank", 2'b11, 7'h7F, 1'b0);
        check("t5_lost.pending", {31'd0, pending}, 32'd0);
        goto(16);
        check("t5_boundary.pending", {31'd0, pending}, 32'd0);
        tick(1);
        check_out("t5_still_00", 2'b11, 7'h40, 1'b1);

        // 6. Free run over four frames showing 11
        do_load(4'd11);
        goto(32);
        fs_count   = 0;
        first_fs_k = -1;
        last_fs_k  = -1;
        bad_gaps   = 0;
        an_zero    = 0;
        an_active  = 0;
        for (int i = 0; i < 64; i++) begin
            tick(1);
            if (frame_start === 1'b1) begin
                if (fs_count == 0) first_fs_k = k;
                else if (k - last_fs_k != 16) bad_gaps++;
                last_fs_k = k;
                fs_count++;
            end
            if (an === 2'b00) an_zero++;
            if (an !== 2'b11) an_active++;
        end
        check("t6_fs_count", fs_count, 32'd4);
        check("t6_first_fs_k", first_fs_k, 32'd33);
        check("t6_fs_period", bad_gaps, 32'd0);
        check("t6_an_never_00", an_zero, 32'd0);
        check("t6_active_cycles", an_active, 32'd48);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
